pumpkin_offcore_arbiter: RTL and testbench
==========================================

// Module: pumpkin_offcore_arbiter
// PURPOSE
//  Shares the single off-core memory port between I-cache refill and D-cache refill/writeback requesters.
//  Round-robin arbitration with one outstanding transaction at a time.
//  Drives the off-core addr/valid/is_write/payload signals and routes the returned payload to the granted requester.
//  Sits between the cache controllers and the top-level off-core interface of pumpkin_cpu_top.
// PARAMETERS
//  ADDR_WIDTH      32   off-core address width (CPU word length)
//  DATA_WIDTH      128  off-core access payload width (OFF_CORE_ACCESS_WIDTH_IN_BITS)
//  TIMEOUT_CYCLES  256  watchdog limit in the WAIT state; used only with the macro
// PORTS
//  clk_in              in   1           clock
//  reset_in            in   1           asynchronous, active-high reset
//  ic_req_valid_in     in   1           I-cache read request
//  ic_req_addr_in      in   ADDR_WIDTH  I-cache request address
//  ic_req_ready_out    out  1           one-cycle pulse: I-cache request accepted
//  ic_resp_valid_out   out  1           one-cycle pulse: I-cache response valid
//  ic_resp_payload_out out  DATA_WIDTH  I-cache response data
//  dc_req_valid_in     in   1           D-cache request
//  dc_req_addr_in      in   ADDR_WIDTH  D-cache request address
//  dc_req_is_write_in  in   1           1 = writeback, 0 = refill
//  dc_req_payload_in   in   DATA_WIDTH  writeback data
//  dc_req_ready_out    out  1           one-cycle pulse: D-cache request accepted
//  dc_resp_valid_out   out  1           one-cycle pulse: D-cache response (read data or write ack)
//  dc_resp_payload_out out  DATA_WIDTH  D-cache response data
//  mem_addr_out        out  ADDR_WIDTH  off-core address
//  mem_addr_valid_out  out  1           off-core request strobe
//  mem_is_write_out    out  1           off-core write flag
//  mem_payload_out     out  DATA_WIDTH  off-core write data
//  mem_payload_in      in   DATA_WIDTH  off-core read data
//  mem_ready_in        in   1           off-core completion pulse
//  timeout_err_out     out  1           sticky watchdog error flag
// BEHAVIOUR
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE
//   - If no request is valid, stay in IDLE.
//   - If exactly one request is valid, grant it.
//   - If both are valid, grant the requester that is not last_grant.
//   - On grant: pulse the winner's req_ready_out, latch addr/is_write/payload (I-cache is_write = 0), update last_grant, go to ISSUE.
//  ISSUE
//   - mem_addr_valid_out = 1 for exactly one cycle; mem_addr/is_write/payload are driven from the latches.
//   - Always go to WAIT.
//  WAIT
//   - mem_addr_valid_out = 0; the address and write data outputs stay held.
//   - On mem_ready_in = 1: capture mem_payload_in (captured as 0 for writes), go to RESP.
//  RESP
//   - Pulse the owner's resp_valid_out with the captured payload; go to IDLE.
//   - A new grant is possible in the next cycle.
//  mem_ready_in outside WAIT is ignored; the memory must pulse it at least 1 cycle after the strobe.
//  Latency: accept at cycle T, strobe at T+1, earliest response at T+3 (ready at T+2); 4-cycle minimum occupancy.
//  Only the owner's resp_valid_out ever pulses; the other requester's valid is held off and is not dropped.
//  Requesters must hold valid/addr/payload stable until they see ready.
//  Reset values:
//   - State IDLE; last_grant = D-cache, so the I-cache wins the first tie.
//   - All ready/valid outputs 0; all addr/payload outputs 0; timeout_err_out = 0.
//  Reset mid-transaction returns to IDLE immediately with no response pulse; requesters must reissue.
// CONFIGURATION
//  OFFCORE_ARB_TIMEOUT_EN defined:
//   - A counter runs in WAIT.
//   - If TIMEOUT_CYCLES elapse without mem_ready_in: set timeout_err_out (sticky until reset), go to RESP, return payload 0.
//  Not defined: no counter; WAIT waits forever; timeout_err_out is tied to 0.
// TESTING
//  1. Lone I-cache read to 0x1000, memory returns 0xA5..A5 after 1 cycle -> ic_resp_valid at T+3 with that data, no dc pulses.
//  2. I-cache and D-cache valid together right after reset -> I-cache granted first; D-cache accepted the cycle after I-cache RESP.
//  3. Both requesters held valid for 6 transactions -> strict I, D, I, D, I, D grant alternation.
//  4. D-cache write to 0x2000 with payload 0x1234 -> mem_is_write = 1, mem_payload_out = 0x1234 during ISSUE; dc_resp pulse with payload 0.
//  5. reset_in asserted during WAIT -> all outputs 0 that cycle; a later mem_ready_in produces no response.
//  6. With OFFCORE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, memory silent -> resp pulse with 0 after 8 WAIT cycles; timeout_err_out = 1 and stays 1.

Source files
------------

// File: rtl/pumpkin_offcore_arbiter.sv
// pumpkin_offcore_arbiter: round-robin sharing of the single off-core memory port between the
// I-cache and D-cache, one transaction in flight. Define OFFCORE_ARB_TIMEOUT_EN for the WAIT watchdog.
module pumpkin_offcore_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  ic_req_valid_in,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr_in,
  output logic                  ic_req_ready_out,
  output logic                  ic_resp_valid_out,
  output logic [DATA_WIDTH-1:0] ic_resp_payload_out,
  input  logic                  dc_req_valid_in,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr_in,
  input  logic                  dc_req_is_write_in,
  input  logic [DATA_WIDTH-1:0] dc_req_payload_in,
  output logic                  dc_req_ready_out,
  output logic                  dc_resp_valid_out,
  output logic [DATA_WIDTH-1:0] dc_resp_payload_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  mem_addr_valid_out,
  output logic                  mem_is_write_out,
  output logic [DATA_WIDTH-1:0] mem_payload_out,
  input  logic [DATA_WIDTH-1:0] mem_payload_in,
  input  logic                  mem_ready_in,
  output logic                  timeout_err_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  state_t                state_reg, state_next;
  logic                  last_grant_reg, last_grant_next;
  logic                  owner_reg, owner_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  is_write_reg, is_write_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                  ic_grant, dc_grant;
  logic                  wait_expired;

`ifdef OFFCORE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             timeout_err_reg, timeout_err_next;

  assign wait_expired    = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err_out = timeout_err_reg;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      wait_cnt_reg    <= wait_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end
`else
  assign wait_expired    = 1'b0;
  assign timeout_err_out = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= OWNER_DC;
      owner_reg      <= OWNER_IC;
      addr_reg       <= '0;
      is_write_reg   <= 1'b0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      addr_reg       <= addr_next;
      is_write_reg   <= is_write_next;
      wdata_reg      <= wdata_next;
      rdata_reg      <= rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    addr_next       = addr_reg;
    is_write_next   = is_write_reg;
    wdata_next      = wdata_reg;
    rdata_next      = rdata_reg;
    ic_grant        = 1'b0;
    dc_grant        = 1'b0;
`ifdef OFFCORE_ARB_TIMEOUT_EN
    wait_cnt_next    = '0;
    timeout_err_next = timeout_err_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (ic_req_valid_in && (!dc_req_valid_in || last_grant_reg == OWNER_DC)) begin
          ic_grant = 1'b1;
        end else if (dc_req_valid_in) begin
          dc_grant = 1'b1;
        end

        if (ic_grant) begin
          addr_next       = ic_req_addr_in;
          is_write_next   = 1'b0;
          wdata_next      = '0;
          owner_next      = OWNER_IC;
          last_grant_next = OWNER_IC;
          state_next      = ST_ISSUE;
        end else if (dc_grant) begin
          addr_next       = dc_req_addr_in;
          is_write_next   = dc_req_is_write_in;
          wdata_next      = dc_req_payload_in;
          owner_next      = OWNER_DC;
          last_grant_next = OWNER_DC;
          state_next      = ST_ISSUE;
        end
      end

      ST_ISSUE: state_next = ST_WAIT;

      ST_WAIT: begin
`ifdef OFFCORE_ARB_TIMEOUT_EN
        wait_cnt_next = wait_cnt_reg + 1'b1;
`endif
        if (mem_ready_in) begin
          rdata_next = is_write_reg ? '0 : mem_payload_in;
          state_next = ST_RESP;
        end else if (wait_expired) begin
          rdata_next = '0;
          state_next = ST_RESP;
`ifdef OFFCORE_ARB_TIMEOUT_EN
          timeout_err_next = 1'b1;
`endif
        end
      end

      ST_RESP: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  // Grants are combinational in IDLE; mask them while reset is held so nothing looks accepted.
  assign ic_req_ready_out = ic_grant & ~reset_in;
  assign dc_req_ready_out = dc_grant & ~reset_in;

  assign mem_addr_valid_out = (state_reg == ST_ISSUE);
  assign mem_addr_out       = addr_reg;
  assign mem_is_write_out   = is_write_reg;
  assign mem_payload_out    = wdata_reg;

  assign ic_resp_valid_out   = (state_reg == ST_RESP) && (owner_reg == OWNER_IC);
  assign dc_resp_valid_out   = (state_reg == ST_RESP) && (owner_reg == OWNER_DC);
  assign ic_resp_payload_out = (owner_reg == OWNER_IC) ? rdata_reg : '0;
  assign dc_resp_payload_out = (owner_reg == OWNER_DC) ? rdata_reg : '0;

endmodule

// File: tb/tb_pumpkin_offcore_arbiter.sv
// Directed bench for pumpkin_offcore_arbiter: scoreboard of expected responses plus a small
// memory responder; timeout scenario runs only when OFFCORE_ARB_TIMEOUT_EN is defined.
module tb_pumpkin_offcore_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;

  typedef struct packed {
    logic          dc;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic          ic_req_valid_in;
  logic [AW-1:0] ic_req_addr_in;
  logic          ic_req_ready_out;
  logic          ic_resp_valid_out;
  logic [DW-1:0] ic_resp_payload_out;
  logic          dc_req_valid_in;
  logic [AW-1:0] dc_req_addr_in;
  logic          dc_req_is_write_in;
  logic [DW-1:0] dc_req_payload_in;
  logic          dc_req_ready_out;
  logic          dc_resp_valid_out;
  logic [DW-1:0] dc_resp_payload_out;
  logic [AW-1:0] mem_addr_out;
  logic          mem_addr_valid_out;
  logic          mem_is_write_out;
  logic [DW-1:0] mem_payload_out;
  logic [DW-1:0] mem_payload_in;
  logic          mem_ready_in;
  logic          timeout_err_out;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  logic mem_silent = 1'b0;

  always #5 clk_in = ~clk_in;

  pumpkin_offcore_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .ic_req_valid_in(ic_req_valid_in), .ic_req_addr_in(ic_req_addr_in),
    .ic_req_ready_out(ic_req_ready_out), .ic_resp_valid_out(ic_resp_valid_out),
    .ic_resp_payload_out(ic_resp_payload_out),
    .dc_req_valid_in(dc_req_valid_in), .dc_req_addr_in(dc_req_addr_in),
    .dc_req_is_write_in(dc_req_is_write_in), .dc_req_payload_in(dc_req_payload_in),
    .dc_req_ready_out(dc_req_ready_out), .dc_resp_valid_out(dc_resp_valid_out),
    .dc_resp_payload_out(dc_resp_payload_out),
    .mem_addr_out(mem_addr_out), .mem_addr_valid_out(mem_addr_valid_out),
    .mem_is_write_out(mem_is_write_out), .mem_payload_out(mem_payload_out),
    .mem_payload_in(mem_payload_in), .mem_ready_in(mem_ready_in),
    .timeout_err_out(timeout_err_out)
  );

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 32'h1000) return {16{8'hA5}};
    return {a, ~a, a + 32'h1, 32'hC0DE_0000 | a};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk_in);
    @(posedge clk_in); #1;
    check(tag, DW'(sb_q.size()), DW'(0));
  endtask

  // Memory model: answers each strobe with ready in the following (WAIT) cycle.
  initial begin
    logic [AW-1:0] a;
    mem_ready_in   = 1'b0;
    mem_payload_in = '0;
    forever begin
      @(negedge clk_in);
      if (mem_addr_valid_out && !mem_silent) begin
        a = mem_addr_out;
        @(posedge clk_in); #1;
        mem_ready_in   = 1'b1;
        mem_payload_in = mem_data(a);
        @(posedge clk_in); #1;
        mem_ready_in   = 1'b0;
        mem_payload_in = '0;
      end
    end
  end

  // Response monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk_in) begin
    exp_t e;
    if (ic_resp_valid_out || dc_resp_valid_out) begin
      check("resp_one_owner", DW'(ic_resp_valid_out & dc_resp_valid_out), DW'(0));
      if (sb_q.size() == 0) begin
        check("resp_unexpected", DW'(1), DW'(0));
      end else begin
        e = sb_q.pop_front();
        $display("resp %s data=%h", dc_resp_valid_out ? "dc" : "ic",
                 dc_resp_valid_out ? dc_resp_payload_out : ic_resp_payload_out);
        check("resp_owner", DW'(dc_resp_valid_out), DW'(e.dc));
        check("resp_data", dc_resp_valid_out ? dc_resp_payload_out : ic_resp_payload_out, e.data);
      end
    end
  end

  initial begin
    int cyc, last_cyc, grants, i_idx, d_idx, k;
    logic granted, got_dc;

    // Reset with both requesters already valid: nothing may be accepted while reset is held.
    reset_in           = 1'b1;
    ic_req_valid_in    = 1'b1;
    ic_req_addr_in     = 32'h100;
    dc_req_valid_in    = 1'b1;
    dc_req_addr_in     = 32'h200;
    dc_req_is_write_in = 1'b0;
    dc_req_payload_in  = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_ic_ready", DW'(ic_req_ready_out), DW'(0));
    check("rst_dc_ready", DW'(dc_req_ready_out), DW'(0));
    check("rst_strobe", DW'(mem_addr_valid_out), DW'(0));
    check("rst_addr", DW'(mem_addr_out), DW'(0));
    check("rst_payload", mem_payload_out, DW'(0));
    check("rst_timeout", DW'(timeout_err_out), DW'(0));

    // Tie right after reset, then both held for 6 transactions: I, D, I, D, I, D.
    for (int n = 0; n < 3; n++) begin
      sb_q.push_back('{dc: 1'b0, data: mem_data(32'h100 + 32'(n * 16))});
      sb_q.push_back('{dc: 1'b1, data: mem_data(32'h200 + 32'(n * 16))});
    end
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    cyc = 0; last_cyc = 0; grants = 0; i_idx = 0; d_idx = 0;
    while (grants < 6 && cyc < 100) begin
      @(negedge clk_in);
      cyc++;
      granted = ic_req_ready_out | dc_req_ready_out;
      got_dc  = dc_req_ready_out;
      if (granted) begin
        check("grant_single", DW'(ic_req_ready_out & dc_req_ready_out), DW'(0));
        check("grant_order", DW'(got_dc), DW'(grants % 2));
        if (grants > 0) check("grant_gap", DW'(cyc - last_cyc), DW'(4));
        $display("grant %0d to %s at cycle %0d", grants, got_dc ? "dc" : "ic", cyc);
        last_cyc = cyc;
        grants++;
      end
      @(posedge clk_in); #1;
      if (granted && !got_dc) begin
        i_idx++;
        ic_req_addr_in = 32'h100 + 32'(i_idx * 16);
        if (i_idx == 3) ic_req_valid_in = 1'b0;
      end else if (granted) begin
        d_idx++;
        dc_req_addr_in = 32'h200 + 32'(d_idx * 16);
        if (d_idx == 3) dc_req_valid_in = 1'b0;
      end
    end
    check("grant_count", DW'(grants), DW'(6));
    wait_drain("drain_alternate");

    // Lone I-cache read of 0x1000: accept T, strobe T+1, response T+3.
    ic_req_valid_in = 1'b1;
    ic_req_addr_in  = 32'h1000;
    sb_q.push_back('{dc: 1'b0, data: {16{8'hA5}}});
    @(negedge clk_in);
    check("t1_ic_ready", DW'(ic_req_ready_out), DW'(1));
    check("t1_dc_ready", DW'(dc_req_ready_out), DW'(0));
    @(posedge clk_in); #1;
    ic_req_valid_in = 1'b0;
    @(negedge clk_in);
    check("t1_strobe", DW'(mem_addr_valid_out), DW'(1));
    check("t1_addr", DW'(mem_addr_out), DW'(32'h1000));
    check("t1_is_write", DW'(mem_is_write_out), DW'(0));
    @(negedge clk_in);
    check("t1_wait_strobe", DW'(mem_addr_valid_out), DW'(0));
    check("t1_wait_addr", DW'(mem_addr_out), DW'(32'h1000));
    @(negedge clk_in);
    check("t1_ic_resp_t3", DW'(ic_resp_valid_out), DW'(1));
    check("t1_no_dc_resp", DW'(dc_resp_valid_out), DW'(0));
    wait_drain("drain_t1");

    // D-cache writeback of 0x1234 to 0x2000; the ack carries payload 0.
    dc_req_valid_in    = 1'b1;
    dc_req_addr_in     = 32'h2000;
    dc_req_is_write_in = 1'b1;
    dc_req_payload_in  = DW'(32'h1234);
    sb_q.push_back('{dc: 1'b1, data: '0});
    @(negedge clk_in);
    check("t4_dc_ready", DW'(dc_req_ready_out), DW'(1));
    @(posedge clk_in); #1;
    dc_req_valid_in    = 1'b0;
    dc_req_is_write_in = 1'b0;
    dc_req_payload_in  = '0;
    @(negedge clk_in);
    check("t4_strobe", DW'(mem_addr_valid_out), DW'(1));
    check("t4_is_write", DW'(mem_is_write_out), DW'(1));
    check("t4_wdata", mem_payload_out, DW'(32'h1234));
    check("t4_addr", DW'(mem_addr_out), DW'(32'h2000));
    wait_drain("drain_t4");

    // Reset in WAIT: outputs clear immediately; a later ready must not produce a response.
    mem_silent      = 1'b1;
    ic_req_valid_in = 1'b1;
    ic_req_addr_in  = 32'h3000;
    @(posedge clk_in); #1;
    ic_req_valid_in = 1'b0;
    @(posedge clk_in); #1;
    reset_in = 1'b1;
    @(negedge clk_in);
    check("t5_strobe", DW'(mem_addr_valid_out), DW'(0));
    check("t5_addr", DW'(mem_addr_out), DW'(0));
    check("t5_ic_resp", DW'(ic_resp_valid_out), DW'(0));
    @(posedge clk_in); #1;
    reset_in       = 1'b0;
    mem_ready_in   = 1'b1;
    mem_payload_in = mem_data(32'h3000);
    @(posedge clk_in); #1;
    mem_ready_in   = 1'b0;
    mem_payload_in = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      check("t5_no_resp", DW'(ic_resp_valid_out | dc_resp_valid_out), DW'(0));
    end

`ifdef OFFCORE_ARB_TIMEOUT_EN
    // Silent memory: response with 0 after 8 WAIT cycles, sticky error flag.
    ic_req_valid_in = 1'b1;
    ic_req_addr_in  = 32'h4000;
    sb_q.push_back('{dc: 1'b0, data: '0});
    @(negedge clk_in);
    check("t6_ic_ready", DW'(ic_req_ready_out), DW'(1));
    @(posedge clk_in); #1;
    ic_req_valid_in = 1'b0;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk_in);
      if (ic_resp_valid_out) k = i;
    end
    check("t6_resp_cycle", DW'(k), DW'(10));
    check("t6_err_set", DW'(timeout_err_out), DW'(1));
    repeat (3) @(negedge clk_in);
    check("t6_err_sticky", DW'(timeout_err_out), DW'(1));
    wait_drain("drain_t6");
`else
    k = 0;
    check("timeout_err_tied", DW'(timeout_err_out), DW'(k));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
